// File: rtl/led_blink_pio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_blink_pio : Avalon-MM LED output PIO with set/clear and blink engine   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module led_blink_pio #(
  parameter int                WIDTH       = 8,
  parameter int                PERIOD_W    = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic                phase;

  logic                wr_en;
  logic [WIDTH-1:0]    wd_bits;
  logic [PERIOD_W-1:0] wd_period;
  logic                period_wr;
  logic                wrap;

  assign wr_en     = chipselect & ~write_n;
  assign wd_bits   = writedata[WIDTH-1:0];
  assign wd_period = writedata[PERIOD_W-1:0];
  assign period_wr = wr_en && (address == ADDR_PERIOD);
  assign wrap      = (counter == period - PERIOD_ONE);

  // DATA and BLINK_MASK registers, including atomic set/clear of DATA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= RESET_VALUE;
      blink_mask <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data       <= wd_bits;
        ADDR_MASK:     blink_mask <= wd_bits;
        ADDR_OUTSET:   data       <= data | wd_bits;
        ADDR_OUTCLEAR: data       <= data & ~wd_bits;
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and overrides a coincident wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= '0;
      counter <= '0;
      phase   <= 1'b0;
    end else if (period_wr) begin
      period  <= wd_period;
      counter <= '0;
      phase   <= 1'b0;
    end else if (period == '0) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (wrap) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + PERIOD_ONE;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata = 32'(data);
      ADDR_MASK:   readdata = 32'(blink_mask);
      ADDR_PERIOD: readdata = 32'(period);
      ADDR_STATUS: readdata = {31'd0, phase};
      default:     readdata = 32'd0;
    endcase
  end

  assign out_port = data & ~(blink_mask & {WIDTH{phase}});

endmodule

`default_nettype wire
